// File: rtl/uart_poller_pkg.sv
// rtl/uart_poller_pkg.sv - shared types and constants for the uart RX poller
package uart_poller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ST_AR,
    ST_R,
    DAT_AR,
    DAT_R,
    GAP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Defaults mirror the uart register map.
  localparam logic [31:0] UART_BASE_DEF  = 32'h0001_0000;
  localparam logic [31:0] STATUS_OFS_DEF = 32'h0000_0014;
  localparam logic [31:0] RXDATA_OFS_DEF = 32'h0000_0018;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 5;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with exact occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_poller.sv
// rtl/uart_rx_poller.sv - AXI4 read master polling a uart and draining RX bytes to a stream FIFO
module uart_rx_poller
  import uart_poller_pkg::*;
#(
  parameter logic [31:0] UART_BASE    = UART_BASE_DEF,
  parameter logic [31:0] STATUS_OFS   = STATUS_OFS_DEF,
  parameter logic [31:0] RXDATA_OFS   = RXDATA_OFS_DEF,
  parameter int          RX_AVAIL_BIT = 1,
  parameter int          POLL_GAP     = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [ADDR_W-1:0]             ar_addr,
  output logic [ID_W-1:0]               ar_id,
  output logic [7:0]                    ar_len,
  output logic [2:0]                    ar_size,
  output logic [1:0]                    ar_burst,
  output logic [2:0]                    ar_prot,
  output logic                          ar_valid,
  input  logic                          ar_ready,
  input  logic [ID_W-1:0]               r_id,
  input  logic [DATA_W-1:0]             r_data,
  input  logic [1:0]                    r_resp,
  input  logic                          r_last,
  input  logic                          r_valid,
  output logic                          r_ready,
  output logic [ADDR_W-1:0]             aw_addr,
  output logic [ID_W-1:0]               aw_id,
  output logic [7:0]                    aw_len,
  output logic [2:0]                    aw_size,
  output logic [1:0]                    aw_burst,
  output logic [2:0]                    aw_prot,
  output logic                          aw_valid,
  input  logic                          aw_ready,
  output logic [DATA_W-1:0]             w_data,
  output logic [DATA_W/8-1:0]           w_strb,
  output logic                          w_last,
  output logic                          w_valid,
  input  logic                          w_ready,
  input  logic [ID_W-1:0]               b_id,
  input  logic [1:0]                    b_resp,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic                          enable,
  input  logic                          rx_irq,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          err
);

  localparam int GW = $clog2(POLL_GAP) + 1;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   gap_cnt;
  logic            gap_done;
  logic            push;
  logic            fifo_empty;
  logic            fifo_full;
  logic            unused_bus;

  assign gap_done = (gap_cnt == GW'(POLL_GAP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Polling only starts with room in the FIFO, so the data read it may lead to always fits.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (enable && !fifo_full) state_nxt = ST_AR;
      ST_AR:  if (ar_ready) state_nxt = ST_R;
      ST_R: begin
        if (r_valid) begin
          if (r_resp != RESP_OKAY)       state_nxt = GAP;
          else if (r_data[RX_AVAIL_BIT]) state_nxt = DAT_AR;
          else                           state_nxt = GAP;
        end
      end
      DAT_AR: if (ar_ready) state_nxt = DAT_R;
      DAT_R:  if (r_valid) state_nxt = (r_resp == RESP_OKAY) ? IDLE : GAP;
      GAP:    if (rx_irq || gap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ar_addr  = '0;
    ar_valid = 1'b0;
    r_ready  = 1'b0;
    push     = 1'b0;
    case (state)
      ST_AR: begin
        ar_addr  = UART_BASE + STATUS_OFS;
        ar_valid = 1'b1;
      end
      ST_R:  r_ready = 1'b1;
      DAT_AR: begin
        ar_addr  = UART_BASE + RXDATA_OFS;
        ar_valid = 1'b1;
      end
      DAT_R: begin
        r_ready = 1'b1;
        push    = r_valid && (r_resp == RESP_OKAY);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              gap_cnt <= '0;
    else if (state == GAP && state_nxt == GAP) gap_cnt <= gap_cnt + GW'(1);
    else                                     gap_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        err <= 1'b0;
    else if (r_valid && r_ready && r_resp != RESP_OKAY) err <= 1'b1;
  end

  assign ar_id    = '0;
  assign ar_len   = '0;
  assign ar_size  = '0;
  assign ar_burst = '0;
  assign ar_prot  = '0;
  assign aw_addr  = '0;
  assign aw_id    = '0;
  assign aw_len   = '0;
  assign aw_size  = '0;
  assign aw_burst = '0;
  assign aw_prot  = '0;
  assign aw_valid = 1'b0;
  assign w_data   = '0;
  assign w_strb   = '0;
  assign w_last   = 1'b0;
  assign w_valid  = 1'b0;
  assign b_ready  = 1'b0;

  assign unused_bus = ^{r_id, r_last, r_data, aw_ready, w_ready, b_id, b_resp, b_valid};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (r_data[7:0]),
    .pop   (m_ready),
    .dout  (m_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  assign m_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_poller.sv
// tb/tb_uart_rx_poller.sv - directed bench with a bus slave model and byte scoreboard
module tb_uart_rx_poller;
  import uart_poller_pkg::*;

  localparam int          POLL_GAP = 16;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] ST_ADDR  = 32'h0001_0014;
  localparam logic [31:0] DT_ADDR  = 32'h0001_0018;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] ar_addr;
  logic [4:0]  ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [2:0]  ar_prot;
  logic        ar_valid;
  logic        ar_ready;
  logic [4:0]  r_id;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] aw_addr;
  logic [4:0]  aw_id;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [2:0]  aw_prot;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic        w_valid;
  logic        w_ready;
  logic [4:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic        enable;
  logic        rx_irq;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  level;
  logic        err;

  uart_rx_poller #(
    .POLL_GAP   (POLL_GAP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready),
    .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .enable(enable), .rx_irq(rx_irq),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .err(err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: always accepts AR, answers R in the following cycle unless a data read is stalled.
  logic [7:0]  src_bytes [64];
  int          src_cnt;
  int          err_at;
  logic        stall_data;
  int          rd_idx = 0;
  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] r_data_q;
  logic [1:0]  r_resp_q;
  logic [31:0] ar_addr_log [$];
  int          ar_cyc_log [$];

  assign ar_ready = 1'b1;
  assign r_valid  = pend && !(stall_data && pend_addr == DT_ADDR);
  assign r_data   = r_data_q;
  assign r_resp   = r_resp_q;
  assign r_id     = '0;
  assign r_last   = 1'b1;
  assign aw_ready = 1'b0;
  assign w_ready  = 1'b0;
  assign b_valid  = 1'b0;
  assign b_id     = '0;
  assign b_resp   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else if (ar_valid && ar_ready) begin
      pend      <= 1'b1;
      pend_addr <= ar_addr;
      ar_addr_log.push_back(ar_addr);
      ar_cyc_log.push_back(cyc);
      if (ar_addr == ST_ADDR) r_data_q <= {30'd0, rd_idx < src_cnt, 1'b0};
      else                    r_data_q <= {24'd0, src_bytes[rd_idx]};
      r_resp_q <= (ar_addr == DT_ADDR && rd_idx == err_at) ? RESP_SLVERR : RESP_OKAY;
    end else if (r_valid && r_ready) begin
      pend <= 1'b0;
      if (pend_addr == DT_ADDR) rd_idx <= rd_idx + 1;
    end
  end

  // Scoreboard logs: expected bytes at each OKAY data beat, observed bytes at each pop.
  logic [7:0] exp_log [$];
  logic [7:0] obs_log [$];
  int         obs_cyc [$];
  int         mv_cycles = 0;
  int         full_push_hits = 0;
  int         exp_rd = 0;
  int         obs_rd = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid) mv_cycles <= mv_cycles + 1;
      if (m_valid && m_ready) begin
        obs_log.push_back(m_data);
        obs_cyc.push_back(cyc);
      end
      if (r_valid && r_ready && pend_addr == DT_ADDR && r_resp == RESP_OKAY) begin
        if (level == 4'(DEPTH)) full_push_hits <= full_push_hits + 1;
        exp_log.push_back(r_data[7:0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ar(input int n, input string tag);
    int k = 0;
    while (ar_addr_log.size() < n && k < 400) begin
      tick(1);
      k++;
    end
    check(tag, 32'(ar_addr_log.size() >= n), 32'd1);
  endtask

  task automatic wait_obs(input int n, input string tag);
    int k = 0;
    while (obs_log.size() < n && k < 400) begin
      tick(1);
      k++;
    end
    check(tag, 32'(obs_log.size() >= n), 32'd1);
  endtask

  task automatic drain_compare(input string tag);
    check({tag, "_count"}, 32'(obs_log.size() - obs_rd), 32'(exp_log.size() - exp_rd));
    while (obs_rd < obs_log.size() && exp_rd < exp_log.size()) begin
      check(tag, 32'(obs_log[obs_rd]), 32'(exp_log[exp_rd]));
      obs_rd++;
      exp_rd++;
    end
    obs_rd = obs_log.size();
    exp_rd = exp_log.size();
  endtask

  initial begin
    int b;
    int s;
    int k;
    int n0;
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; rx_irq = 1'b0;
    stall_data = 1'b0; err_at = -1; src_cnt = 0;
    for (int i = 0; i < 64; i++) src_bytes[i] = 8'h00;
    tick(3);

    check("rst_ar_valid", 32'(ar_valid), 32'd0);
    check("rst_ar_addr", ar_addr, 32'd0);
    check("rst_r_ready", 32'(r_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("tie_ctrl", 32'({aw_valid, w_valid, b_ready}), 32'd0);
    check("tie_aw_addr", aw_addr, 32'd0);
    check("tie_w_data", w_data, 32'd0);
    check("tie_fields", 32'({ar_id, ar_len, ar_size, ar_burst, ar_prot,
                             aw_id, aw_len, aw_size, aw_burst, aw_prot}), 32'd0);
    check("tie_w_misc", 32'({w_strb, w_last}), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Nothing available: three status polls, each separated by ST_R + POLL_GAP + IDLE.
    b = ar_addr_log.size();
    enable = 1'b1;
    wait_ar(b + 3, "poll3_wait");
    enable = 1'b0;
    tick(40);
    check("poll3_count", 32'(ar_addr_log.size() - b), 32'd3);
    for (int i = 0; i < 3; i++) check("poll3_addr", ar_addr_log[b + i], ST_ADDR);
    check("poll3_delta1", 32'(ar_cyc_log[b + 1] - ar_cyc_log[b]), 32'(POLL_GAP + 3));
    check("poll3_delta2", 32'(ar_cyc_log[b + 2] - ar_cyc_log[b + 1]), 32'(POLL_GAP + 3));
    check("poll3_m_valid", 32'(mv_cycles), 32'd0);

    // Two bytes streamed straight through.
    src_bytes[0] = 8'h48; src_bytes[1] = 8'h65; src_cnt = 2;
    m_ready = 1'b1;
    s = mv_cycles;
    n0 = obs_log.size();
    b = ar_addr_log.size();
    enable = 1'b1;
    wait_obs(n0 + 2, "bytes_wait");
    enable = 1'b0;
    tick(40);
    check("bytes_first", 32'(obs_log[n0]), 32'h48);
    check("bytes_second", 32'(obs_log[n0 + 1]), 32'h65);
    check("bytes_mv_cycles", 32'(mv_cycles - s), 32'd2);
    check("bytes_latency", 32'(obs_cyc[n0] - ar_cyc_log[b]), 32'd4);
    check("bytes_ar0", ar_addr_log[b], ST_ADDR);
    check("bytes_ar1", ar_addr_log[b + 1], DT_ADDR);
    check("bytes_ar2", ar_addr_log[b + 2], ST_ADDR);
    check("bytes_ar3", ar_addr_log[b + 3], DT_ADDR);
    check("bytes_level", 32'(level), 32'd0);
    drain_compare("bytes_sb");

    // Fill the FIFO with the consumer stalled, then release it.
    for (int i = 0; i < 8; i++) src_bytes[2 + i] = 8'(i);
    src_cnt = 10;
    m_ready = 1'b0;
    b = ar_addr_log.size();
    n0 = obs_log.size();
    enable = 1'b1;
    k = 0;
    while (level != 4'(DEPTH) && k < 300) begin
      tick(1);
      k++;
    end
    tick(30);
    check("fill_level", 32'(level), 32'(DEPTH));
    check("fill_ar_count", 32'(ar_addr_log.size() - b), 32'd16);
    m_ready = 1'b1;
    wait_obs(n0 + 8, "fill_drain_wait");
    tick(5);
    check("fill_repoll", 32'(ar_addr_log.size() > b + 16), 32'd1);
    check("fill_repoll_addr", ar_addr_log[b + 16], ST_ADDR);
    for (int i = 0; i < 8; i++) check("fill_order", 32'(obs_log[n0 + i]), i);
    enable = 1'b0;
    tick(40);
    drain_compare("fill_sb");

    // SLVERR on a data read: sticky err, no push, next poll after the gap.
    src_bytes[10] = 8'h5A; src_bytes[11] = 8'h5B; src_cnt = 12; err_at = 10;
    check("slverr_err_before", 32'(err), 32'd0);
    b = ar_addr_log.size();
    n0 = obs_log.size();
    enable = 1'b1;
    wait_ar(b + 3, "slverr_wait");
    check("slverr_ar_data", ar_addr_log[b + 1], DT_ADDR);
    check("slverr_ar_next", ar_addr_log[b + 2], ST_ADDR);
    check("slverr_gap", 32'(ar_cyc_log[b + 2] - ar_cyc_log[b + 1]), 32'(POLL_GAP + 3));
    check("slverr_err", 32'(err), 32'd1);
    check("slverr_no_push", 32'(m_valid), 32'd0);
    wait_obs(n0 + 1, "slverr_ok_wait");
    check("slverr_ok_byte", 32'(obs_log[n0]), 32'h5B);
    check("slverr_sticky", 32'(err), 32'd1);
    enable = 1'b0;
    tick(40);
    drain_compare("slverr_sb");

    // rx_irq with 10 GAP cycles left cuts the wait to two cycles.
    b = ar_addr_log.size();
    enable = 1'b1;
    wait_ar(b + 1, "irq_first_wait");
    s = ar_cyc_log[b];
    k = 0;
    while (cyc < s + 8 && k < 40) begin
      tick(1);
      k++;
    end
    rx_irq = 1'b1;
    tick(1);
    rx_irq = 1'b0;
    wait_ar(b + 2, "irq_second_wait");
    enable = 1'b0;
    check("irq_delta", 32'(ar_cyc_log[b + 1] - s), 32'd10);
    check("irq_addr", ar_addr_log[b + 1], ST_ADDR);
    tick(40);

    // Reset while a data read is outstanding with three bytes buffered.
    for (int i = 0; i < 4; i++) src_bytes[12 + i] = 8'(i + 1);
    src_cnt = 16;
    m_ready = 1'b0;
    enable = 1'b1;
    k = 0;
    while (level != 4'd3 && k < 200) begin
      tick(1);
      k++;
    end
    stall_data = 1'b1;
    k = 0;
    while (!(r_ready && pend && pend_addr == DT_ADDR) && k < 40) begin
      tick(1);
      k++;
    end
    check("rst_mid_dat_r", 32'(r_ready), 32'd1);
    check("rst_mid_level", 32'(level), 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ar_valid", 32'(ar_valid), 32'd0);
    check("rst_mid_r_ready", 32'(r_ready), 32'd0);
    check("rst_mid_m_valid", 32'(m_valid), 32'd0);
    check("rst_mid_level0", 32'(level), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    tick(2);
    stall_data = 1'b0;
    m_ready = 1'b1;
    exp_rd = exp_log.size();
    obs_rd = obs_log.size();
    b = ar_addr_log.size();
    n0 = obs_log.size();
    rst_n = 1'b1;
    wait_ar(b + 1, "post_rst_wait");
    check("post_rst_addr", ar_addr_log[b], ST_ADDR);
    wait_obs(n0 + 1, "post_rst_byte_wait");
    check("post_rst_byte", 32'(obs_log[n0]), 32'h04);
    enable = 1'b0;
    tick(40);
    drain_compare("post_rst_sb");

    check("no_push_when_full", 32'(full_push_hits), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
